// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {REQ_IF, REQ_D} req_id_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester not served last wins.
module rr_pick2 (
  input  logic req_if,
  input  logic req_d,
  input  logic last_d,
  output logic valid,
  output logic pick_d
);

  assign valid  = req_if | req_d;
  assign pick_d = req_d & (~req_if | ~last_d);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between instruction fetch and load/store:
// grant pulse, MEM_LAT wait states, then a done pulse carrying read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state, w_state_nxt;
  req_id_t           r_win;
  logic              r_we, r_last_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_if_gnt, r_d_gnt, r_if_done, r_d_done, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic              w_valid, w_pick_d, w_win, w_last;

  rr_pick2 u_pick (
    .req_if (if_req),
    .req_d  (d_req),
    .last_d (r_last_d),
    .valid  (w_valid),
    .pick_d (w_pick_d)
  );

  // IDLE and DONE are both arbitration points; ACCESS ignores all requests.
  assign w_win  = ((r_state == IDLE) || (r_state == DONE)) && w_valid;
  assign w_last = (r_state == ACCESS) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_state_nxt = w_valid ? ACCESS : IDLE;
      ACCESS:     if (w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win       <= REQ_IF;
      r_we        <= 1'b0;
      r_last_d    <= 1'b0;
      r_cnt       <= '0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_gnt  <= w_win & ~w_pick_d;
      r_d_gnt   <= w_win & w_pick_d;
      r_if_done <= w_last && (r_win == REQ_IF);
      r_d_done  <= w_last && (r_win == REQ_D);
      r_mem_wr  <= w_win & w_pick_d & d_we;
      r_cnt     <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
      if (w_win) begin
        r_last_d    <= w_pick_d;
        r_win       <= w_pick_d ? REQ_D : REQ_IF;
        r_we        <= w_pick_d & d_we;
        r_mem_addr  <= w_pick_d ? d_addr : if_addr;
        r_mem_wdata <= w_pick_d ? d_wdata : '0;
      end
      // Read data is valid on the edge that closes the last wait state.
      if (w_last && !r_we) begin
        if (r_win == REQ_D) r_d_rdata  <= mem_rdata;
        else                r_if_rdata <= mem_rdata;
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2 and MEM_LAT=4.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic        if_gnt, if_done, d_gnt, d_done, mem_wr;
  logic [63:0] if_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_addr;

  logic        if_req4, d_req4, d_we4;
  logic [31:0] if_addr4, d_addr4;
  logic [63:0] d_wdata4, mem_rdata4;
  logic        if_gnt4, if_done4, d_gnt4, d_done4, mem_wr4;
  logic [63:0] if_rdata4, d_rdata4, mem_wdata4;
  logic [31:0] mem_addr4;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(4), .ADDR_W(32), .DATA_W(64)) dut4 (
    .clk(clk), .reset(reset),
    .if_req(if_req4), .if_addr(if_addr4), .if_gnt(if_gnt4), .if_done(if_done4), .if_rdata(if_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_gnt(d_gnt4), .d_done(d_done4), .d_rdata(d_rdata4),
    .mem_addr(mem_addr4), .mem_wr(mem_wr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_req4 = 0; d_req4 = 0; d_we4 = 0; if_addr4 = '0; d_addr4 = '0; d_wdata4 = '0; mem_rdata4 = '0;
    nxt; nxt;
    chk("rst_gnt",   {62'd0, if_gnt, d_gnt}, 64'd0);
    chk("rst_done",  {62'd0, if_done, d_done}, 64'd0);
    chk("rst_memwr", {63'd0, mem_wr}, 64'd0);
    chk("rst_addr",  {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rdata", if_rdata | d_rdata, 64'd0);
    chk("rst_state", dut.r_state, IDLE);
    chk("rst4_out",  {if_gnt4, if_done4, d_gnt4, d_done4, mem_wr4}, 64'd0);
    reset = 1'b0;
    nxt;

    // Load from 0x40, memory answers in the second wait state.
    d_req = 1; d_we = 0; d_addr = 32'h40;
    nxt;
    chk("ld_gnt", d_gnt, 1); chk("ld_addr", mem_addr, 64'h40); chk("ld_wr", mem_wr, 0);
    chk("ld_ignt", if_gnt, 0);
    d_req = 0;
    nxt;
    chk("ld_gnt_c2", d_gnt, 0); chk("ld_done_c2", d_done, 0);
    mem_rdata = 64'hDEAD_BEEF;
    nxt;
    chk("ld_done", d_done, 1); chk("ld_rdata", d_rdata, 64'hDEAD_BEEF); chk("ld_ifrdata", if_rdata, 0);
    mem_rdata = 64'h5555;
    nxt;
    chk("ld_done_c4", d_done, 0);

    // Store to 0x80; the read bus carries junk that must not be captured.
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 64'h1234;
    nxt;
    chk("st_wr_c1", mem_wr, 1); chk("st_addr", mem_addr, 64'h80); chk("st_wdata", mem_wdata, 64'h1234);
    chk("st_gnt", d_gnt, 1);
    d_req = 0; d_we = 0;
    nxt;
    chk("st_wr_c2", mem_wr, 0); chk("st_addr_c2", mem_addr, 64'h80); chk("st_wdata_c2", mem_wdata, 64'h1234);
    nxt;
    chk("st_done", d_done, 1); chk("st_rdata", d_rdata, 64'hDEAD_BEEF); chk("st_wr_c3", mem_wr, 0);
    mem_rdata = '0;
    nxt;

    // Reset during the grant cycle of a store.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 64'hAA;
    nxt;
    chk("rs_wr_pre", mem_wr, 1);
    d_req = 0; d_we = 0;
    #2 reset = 1'b1;
    #1;
    chk("rs_wr_async", mem_wr, 0); chk("rs_gnt_async", d_gnt, 0);
    nxt;
    reset = 1'b0;
    nxt;
    chk("rs_done", d_done, 0); chk("rs_rdata", d_rdata, 0); chk("rs_addr", mem_addr, 0);
    chk("rs_state", dut.r_state, IDLE);
    nxt;
    chk("rs_done2", d_done, 0); chk("rs_out", {if_gnt, if_done, d_gnt, mem_wr}, 0);

    // Both requesters contend continuously: D, I, D, I.
    if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h20; d_we = 0;
    for (int c = 1; c <= 12; c++) begin
      nxt;
      chk($sformatf("alt_dgnt_c%0d", c),  d_gnt,   (c == 1 || c == 7));
      chk($sformatf("alt_ignt_c%0d", c),  if_gnt,  (c == 4 || c == 10));
      chk($sformatf("alt_ddone_c%0d", c), d_done,  (c == 3 || c == 9));
      chk($sformatf("alt_idone_c%0d", c), if_done, (c == 6 || c == 12));
      if (c == 12) begin
        if_req = 0; d_req = 0;
      end else begin
        if_req = ~if_gnt; d_req = ~d_gnt;
      end
    end
    nxt;
    chk("alt_idle", dut.r_state, IDLE);

    // Fetch alone, then a load arriving mid-fetch goes DONE -> ACCESS directly.
    if_req = 1; if_addr = 32'h0; mem_rdata = 64'hF00D;
    nxt;
    chk("fd_ignt", if_gnt, 1); chk("fd_addr", mem_addr, 0);
    if_req = 0;
    nxt;
    d_req = 1; d_we = 0; d_addr = 32'h44;
    nxt;
    chk("fd_idone", if_done, 1); chk("fd_irdata", if_rdata, 64'hF00D); chk("fd_dgnt_c3", d_gnt, 0);
    chk("fd_state_c3", dut.r_state, DONE);
    nxt;
    chk("fd_dgnt", d_gnt, 1); chk("fd_daddr", mem_addr, 64'h44); chk("fd_state_c4", dut.r_state, ACCESS);
    d_req = 0;
    nxt;
    nxt;
    chk("fd_ddone", d_done, 1); chk("fd_drdata", d_rdata, 64'hF00D);

    // MEM_LAT=4 single fetch.
    if_req4 = 1; if_addr4 = 32'h200;
    nxt;
    chk("l4_gnt", if_gnt4, 1); chk("l4_addr", mem_addr4, 64'h200);
    if_req4 = 0; mem_rdata4 = 64'hCAFE;
    for (int c = 2; c <= 4; c++) begin
      nxt;
      chk($sformatf("l4_done_c%0d", c), if_done4, 0);
    end
    nxt;
    chk("l4_done_c5", if_done4, 1); chk("l4_rdata", if_rdata4, 64'hCAFE);
    nxt;
    chk("l4_done_c6", if_done4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-port main memory between the instruction-fetch path and the load/store path of the multicycle core. Each access is accepted with a one-cycle grant, held against the memory for a fixed wait-state count, and finished with a one-cycle done pulse that carries read data. Arbitration is two-way round-robin, so neither fetch nor data traffic can starve the other. It sits between the control FSM's memory-read/write strobes and the memory macro.

## Interface
- MEM_LAT, 2: memory read latency in cycles from address presented to `mem_rdata` valid; legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 64: data word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address; sampled on grant.
- if_gnt  out  1  fetch accepted; 1-cycle pulse.
- if_done  out  1  fetch complete; 1-cycle pulse.
- if_rdata  out  DATA_W  fetched word; valid from `if_done` until the next `if_done`.
- d_req  in  1  data request, level.
- d_we  in  1  1 = store, 0 = load; sampled on grant.
- d_addr  in  ADDR_W  data address; sampled on grant.
- d_wdata  in  DATA_W  store data; sampled on grant.
- d_gnt  out  1  data accepted; 1-cycle pulse.
- d_done  out  1  data access complete; 1-cycle pulse.
- d_rdata  out  DATA_W  load word; a store leaves it unchanged.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - `last_d` (last served was data) is 0.
- States:
  - IDLE: arbitration point.
  - ACCESS: lasts exactly MEM_LAT cycles, timed by a wait counter of width clog2(MEM_LAT)+1.
  - DONE: lasts 1 cycle and is also an arbitration point.
- Arbitration (in IDLE or DONE):
  - If exactly one request is high, that requester wins.
  - If both are high, the requester not served last wins: `last_d`=1 gives fetch, `last_d`=0 gives data.
  - If neither is high, DONE goes to IDLE and IDLE stays IDLE.
- On a win:
  - The next state is ACCESS.
  - Address, `we` and `wdata` are registered into `mem_*`.
  - The winner id is registered.
  - The winner's gnt is high in the first ACCESS cycle.
  - `last_d` is updated.
- Requester rules:
  - Each requester deasserts req by the edge that ends its gnt cycle.
  - After gnt, the arbiter ignores that requester's req until DONE.
  - A req that is still high in DONE is treated as a new request.
- During ACCESS:
  - `mem_wr` equals the registered `we` in the first ACCESS cycle only, and is 0 otherwise.
  - `mem_addr` and `mem_wdata` are held stable for all of ACCESS.
- Capture: on the edge that ends the last ACCESS cycle, for a read, `mem_rdata` is captured into the winner's rdata register.
- DONE: the winner's done is high for exactly 1 cycle.
- Reset mid-access:
  - The access is aborted and `mem_wr` drops immediately, asynchronously.
  - No done is issued and the rdata registers clear.

## Timing
- Request at cycle 0 in IDLE:
  - gnt in cycle 1.
  - ACCESS cycles 1..MEM_LAT.
  - done in cycle MEM_LAT+1.
  - Request-to-done latency is MEM_LAT+1 cycles.
- Back-to-back:
  - DONE goes directly to ACCESS when a request is pending.
  - Sustained throughput is one access per MEM_LAT+1 cycles.
- Alternation: with both reqs continuously reasserted, grants alternate D, I, D, I. Worst-case wait for a waiting requester is one full access plus its own.
- Outputs: gnt, done and `mem_*` are all registered, with no combinational path from input to output.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` {IDLE, ACCESS, DONE}.
  - `req_id_t` {REQ_IF, REQ_D}.
  - Defaults for ADDR_W and DATA_W.
- Sub-module `rr_pick2`:
  - Combinational two-way round-robin picker.
  - Inputs: `req_if`, `req_d`, `last_d`.
  - Outputs: `valid`, `pick_d`.
- The top module holds the FSM, wait counter, capture registers and the `last_d` register.

## Test plan
- MEM_LAT=2, `d_req` with `d_we`=0 and `d_addr`=0x40 at cycle 0, memory returns 0xDEAD_BEEF at the second ACCESS cycle:
  - `d_gnt` at cycle 1, `mem_addr`=0x40, `mem_wr`=0.
  - `d_done` at cycle 3, `d_rdata`=0xDEAD_BEEF.
  - `if_rdata` unchanged.
- Store with `d_addr`=0x80 and `d_wdata`=0x1234:
  - `mem_wr`=1 only in cycle 1, with `mem_addr`=0x80 and `mem_wdata`=0x1234.
  - `d_done` at cycle 3, `d_rdata` unchanged.
- `if_req` and `d_req` both held high (re-raised after each gnt) from reset:
  - Grant order D, I, D, I.
  - dones at cycles 3, 6, 9, 12.
- `if_req` alone at cycle 0 with `if_addr`=0x0, then `d_req` at cycle 2:
  - fetch done at cycle 3.
  - `d_gnt` at cycle 4, with no IDLE cycle in between.
- `reset` asserted in cycle 1 of a store:
  - `mem_wr` falls within cycle 1.
  - No `d_done`; state is IDLE and all outputs are 0 after release.
- MEM_LAT=4, single fetch: `if_done` exactly 5 cycles after the request cycle.
